// File: rtl/jpeg_pkg.sv
// -----------------------------------------------------------------------------
// jpeg_pkg
// Shared JPEG constants and types.
//   ZZ2RASTER[k] : raster position (row*8+col) of zig-zag index k
//   RASTER2ZZ[r] : zig-zag index of raster position r (encoder side)
//   wr_state_e   : write-side state of the inverse zig-zag block
//   AXIS_*_W     : field widths of the AXI4-Stream interface
// -----------------------------------------------------------------------------
package jpeg_pkg;

    localparam int AXIS_TDATA_W = 16;
    localparam int AXIS_ID_W    = 4;
    localparam int AXIS_DEST_W  = 4;
    localparam int AXIS_USER_W  = 1;

    localparam logic [5:0] ZZ2RASTER [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    localparam logic [5:0] RASTER2ZZ [64] = '{
        6'd0,  6'd1,  6'd5,  6'd6,  6'd14, 6'd15, 6'd27, 6'd28,
        6'd2,  6'd4,  6'd7,  6'd13, 6'd16, 6'd26, 6'd29, 6'd42,
        6'd3,  6'd8,  6'd12, 6'd17, 6'd25, 6'd30, 6'd41, 6'd43,
        6'd9,  6'd11, 6'd18, 6'd24, 6'd31, 6'd40, 6'd44, 6'd53,
        6'd10, 6'd19, 6'd23, 6'd32, 6'd39, 6'd45, 6'd52, 6'd54,
        6'd20, 6'd22, 6'd33, 6'd38, 6'd46, 6'd51, 6'd55, 6'd60,
        6'd21, 6'd34, 6'd37, 6'd47, 6'd50, 6'd56, 6'd59, 6'd61,
        6'd35, 6'd36, 6'd48, 6'd49, 6'd57, 6'd58, 6'd62, 6'd63
    };

    typedef enum logic [0:0] {
        WR_LOAD = 1'b0,
        WR_FILL = 1'b1
    } wr_state_e;

endpackage

// File: rtl/axi4_stream_if.sv
// -----------------------------------------------------------------------------
// axi4_stream_if
// AXI4-Stream bundle with master/slave modports.
//   master : drives tvalid/tdata/tkeep/tstrb/tlast/tid/tdest/tuser, samples tready
//   slave  : samples the payload, drives tready
// -----------------------------------------------------------------------------
interface axi4_stream_if #(
    parameter int TDATA_W = 16,
    parameter int TID_W   = 4,
    parameter int TDEST_W = 4,
    parameter int TUSER_W = 1
);
    logic                 tvalid;
    logic                 tready;
    logic [TDATA_W-1:0]   tdata;
    logic [TDATA_W/8-1:0] tkeep;
    logic [TDATA_W/8-1:0] tstrb;
    logic                 tlast;
    logic [TID_W-1:0]     tid;
    logic [TDEST_W-1:0]   tdest;
    logic [TUSER_W-1:0]   tuser;

    modport master (
        output tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
        output tready
    );
endinterface

// File: rtl/zz_pingpong_buf.sv
// -----------------------------------------------------------------------------
// zz_pingpong_buf
// Two banks of 64 coefficient registers: one indexed write port and a
// combinational read mux. Bank selection and occupancy are owned by the parent.
//   clk_i      : clock
//   we_i       : write enable
//   wr_bank_i  : bank written
//   wr_addr_i  : raster address written
//   wr_data_i  : coefficient written
//   rd_bank_i  : bank read
//   rd_addr_i  : raster address read
//   rd_data_o  : coefficient at rd_bank_i/rd_addr_i
// -----------------------------------------------------------------------------
module zz_pingpong_buf #(
    parameter int DATA_WIDTH = 12
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic                  wr_bank_i,
    input  logic [5:0]            wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_bank_i,
    input  logic [5:0]            rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    // Pure data storage: no reset, contents are only meaningful once the
    // parent has marked a bank full.
    logic [DATA_WIDTH-1:0] mem_q [2][64];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[wr_bank_i][wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_bank_i][rd_addr_i];

endmodule

// File: rtl/inv_zig_zag.sv
// -----------------------------------------------------------------------------
// inv_zig_zag
// Inverse zig-zag reorder: accepts 8x8 coefficient blocks in zig-zag order and
// emits them in raster order through a ping-pong register store, one
// coefficient per cycle sustained.
//   clk_i     : clock
//   rst_i     : asynchronous active-high reset
//   zz_i      : AXI4-Stream slave, zig-zag ordered coefficients, tlast = end of block
//   raster_o  : AXI4-Stream master, raster ordered coefficients, tlast on index 63
//   err_o     : one-cycle pulse on a framing error
// Build option:
//   INV_ZZ_EOB_FILL_EN : an early tlast zero-fills the rest of the block
//                        (FILL state) instead of flagging err_o.
// -----------------------------------------------------------------------------
module inv_zig_zag
    import jpeg_pkg::*;
#(
    parameter int DATA_WIDTH = 12
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    axi4_stream_if.slave         zz_i,
    axi4_stream_if.master        raster_o,
    output logic                 err_o
);

    wr_state_e state_q, state_d;
    logic [1:0] full_q, full_d;
    logic       wr_sel_q, wr_sel_d;
    logic       rd_sel_q, rd_sel_d;
    logic [5:0] wr_idx_q, wr_idx_d;
    logic [5:0] rd_idx_q, rd_idx_d;
    logic       err_q, err_d;

    logic                  in_ready;
    logic                  in_hs;
    logic                  out_hs;
    logic                  commit;
    logic                  buf_we;
    logic [5:0]            buf_waddr;
    logic [DATA_WIDTH-1:0] buf_wdata;
    logic [DATA_WIDTH-1:0] buf_rdata;

    // Input side never looks at raster_o.tready: only the bank flags and state.
    assign in_ready = (state_q == WR_LOAD) && !full_q[wr_sel_q];
    assign in_hs    = zz_i.tvalid && in_ready;
    assign out_hs   = full_q[rd_sel_q] && raster_o.tready;

    always_comb begin
        state_d   = state_q;
        full_d    = full_q;
        wr_sel_d  = wr_sel_q;
        rd_sel_d  = rd_sel_q;
        wr_idx_d  = wr_idx_q;
        rd_idx_d  = rd_idx_q;
        err_d     = 1'b0;
        commit    = 1'b0;
        buf_we    = 1'b0;
        buf_waddr = ZZ2RASTER[wr_idx_q];
        buf_wdata = zz_i.tdata[DATA_WIDTH-1:0];

        case (state_q)
            WR_LOAD: begin
                if (in_hs) begin
                    buf_we = 1'b1;
                    if (wr_idx_q == 6'd63) begin
                        commit = 1'b1;
                        err_d  = !zz_i.tlast;
                    end else begin
                        wr_idx_d = wr_idx_q + 6'd1;
                        if (zz_i.tlast) begin
`ifdef INV_ZZ_EOB_FILL_EN
                            state_d = WR_FILL;
`else
                            // Count-based framing: flag it and keep filling.
                            err_d = 1'b1;
`endif
                        end
                    end
                end
            end
            WR_FILL: begin
                // Zero the remaining zig-zag positions, one per cycle.
                buf_we    = 1'b1;
                buf_wdata = '0;
                if (wr_idx_q == 6'd63) begin
                    commit  = 1'b1;
                    state_d = WR_LOAD;
                end else begin
                    wr_idx_d = wr_idx_q + 6'd1;
                end
            end
            default: state_d = WR_LOAD;
        endcase

        // Commit and drain always touch different banks, so both may apply.
        if (commit) begin
            full_d[wr_sel_q] = 1'b1;
            wr_sel_d         = !wr_sel_q;
            wr_idx_d         = 6'd0;
        end

        if (out_hs) begin
            if (rd_idx_q == 6'd63) begin
                full_d[rd_sel_q] = 1'b0;
                rd_sel_d         = !rd_sel_q;
                rd_idx_d         = 6'd0;
            end else begin
                rd_idx_d = rd_idx_q + 6'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= WR_LOAD;
            full_q   <= 2'b00;
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            wr_idx_q <= 6'd0;
            rd_idx_q <= 6'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            full_q   <= full_d;
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            err_q    <= err_d;
        end
    end

    zz_pingpong_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk_i     (clk_i),
        .we_i      (buf_we),
        .wr_bank_i (wr_sel_q),
        .wr_addr_i (buf_waddr),
        .wr_data_i (buf_wdata),
        .rd_bank_i (rd_sel_q),
        .rd_addr_i (rd_idx_q),
        .rd_data_o (buf_rdata)
    );

    assign zz_i.tready = in_ready;

    // The read bank is full and never written, so tdata holds under backpressure.
    assign raster_o.tvalid = full_q[rd_sel_q];
    assign raster_o.tdata  = AXIS_TDATA_W'(buf_rdata);
    assign raster_o.tlast  = (rd_idx_q == 6'd63);
    assign raster_o.tkeep  = '1;
    assign raster_o.tstrb  = '1;
    assign raster_o.tid    = '0;
    assign raster_o.tdest  = '0;
    assign raster_o.tuser  = '0;

    assign err_o = err_q;

    // Sideband inputs carry nothing this block uses.
    logic unused_in;
    assign unused_in = ^{zz_i.tdata, zz_i.tkeep, zz_i.tstrb, zz_i.tid,
                         zz_i.tdest, zz_i.tuser};

endmodule

// File: tb/tb_inv_zig_zag.sv
module tb_inv_zig_zag;
    localparam int DW = 12;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } src_t;

    typedef struct {
        logic [15:0] data;
        logic        last;
        int          cyc;
    } out_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic err;

    axi4_stream_if zz_if ();
    axi4_stream_if rs_if ();

    inv_zig_zag #(.DATA_WIDTH(DW)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .zz_i     (zz_if),
        .raster_o (rs_if),
        .err_o    (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    src_t        src_q[$];
    logic [16:0] exp_q[$];
    out_t        out_q[$];
    int          zz2r[64];

    // ---------------- monitors (negedge sampling) ----------------
    int   cyc = 0;
    logic in_fire = 1'b0;
    int   n_in = 0, n_err = 0, n_src_stall = 0, n_rdy_low = 0, n_unstable = 0;
    int   t_last_in = -1, vld_rise_cyc = -1;
    logic prev_vld = 1'b0, prev_stall = 1'b0, prev_last = 1'b0;
    logic [15:0] prev_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        in_fire <= zz_if.tvalid && zz_if.tready && !rst;
        if (!rst) begin
            if (zz_if.tvalid && zz_if.tready) begin
                n_in <= n_in + 1;
                if (zz_if.tlast) t_last_in <= cyc;
            end
            if (zz_if.tvalid && !zz_if.tready) n_src_stall <= n_src_stall + 1;
            if (!zz_if.tready) n_rdy_low <= n_rdy_low + 1;
            if (rs_if.tvalid && rs_if.tready)
                out_q.push_back('{data: rs_if.tdata, last: rs_if.tlast, cyc: cyc});
            if (rs_if.tvalid && !prev_vld) vld_rise_cyc <= cyc;
            if (prev_stall && (!rs_if.tvalid || rs_if.tdata !== prev_data || rs_if.tlast !== prev_last))
                n_unstable <= n_unstable + 1;
            if (err) n_err <= n_err + 1;
        end
        prev_vld   <= rs_if.tvalid && !rst;
        prev_stall <= rs_if.tvalid && !rs_if.tready && !rst;
        prev_data  <= rs_if.tdata;
        prev_last  <= rs_if.tlast;
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Zig-zag walk over anti-diagonals: odd diagonals run down-left,
    // even diagonals run up-right.
    task automatic build_model();
        int k = 0;
        for (int s = 0; s < 15; s++) begin
            int lo = (s > 7) ? s - 7 : 0;
            int hi = (s < 7) ? s : 7;
            if (s % 2 == 1) begin
                for (int r = lo; r <= hi; r++) begin zz2r[k] = r * 8 + (s - r); k++; end
            end else begin
                for (int r = hi; r >= lo; r--) begin zz2r[k] = r * 8 + (s - r); k++; end
            end
        end
    endtask

    // Queue one block of zig-zag input; last_at marks the (possibly early) tlast.
    task automatic push_block(input int vals[64], input int last_at, input bit fill_mode);
        int raster[64];
        int n_src = fill_mode ? last_at + 1 : 64;
        for (int i = 0; i < n_src; i++)
            src_q.push_back('{d: DW'(vals[i]), l: (i == last_at) || (i == 63)});
        for (int r = 0; r < 64; r++) raster[r] = 0;
        for (int k = 0; k < 64; k++)
            raster[zz2r[k]] = (k < n_src) ? vals[k] : 0;
        for (int r = 0; r < 64; r++)
            exp_q.push_back({(r == 63), 16'(raster[r])});
    endtask

    task automatic step(input int vpct, input int rpct);
        src_t s;
        @(posedge clk); #1;
        if (!(zz_if.tvalid && !in_fire)) begin
            if (src_q.size() > 0 && int'($urandom_range(99)) < vpct) begin
                s = src_q.pop_front();
                zz_if.tvalid = 1'b1;
                zz_if.tdata  = 16'(s.d);
                zz_if.tlast  = s.l;
            end else begin
                zz_if.tvalid = 1'b0;
                zz_if.tlast  = 1'b0;
                zz_if.tdata  = 16'($urandom_range(65535));
            end
        end
        rs_if.tready = int'($urandom_range(99)) < rpct;
    endtask

    task automatic drain(input string tag, input int vpct, input int rpct, input int limit);
        int n = 0;
        while (!(src_q.size() == 0 && !zz_if.tvalid && out_q.size() >= exp_q.size()) && n < limit) begin
            step(vpct, rpct);
            n++;
        end
        check({tag, "_done"}, 64'(n < limit), 64'd1);
    endtask

    task automatic compare_out(input string tag);
        int mism;
        int nblk = exp_q.size() / 64;
        check({tag, "_count"}, 64'(out_q.size()), 64'(exp_q.size()));
        for (int b = 0; b < nblk; b++) begin
            mism = 0;
            for (int i = 0; i < 64; i++) begin
                int idx = b * 64 + i;
                if (idx >= out_q.size() || {out_q[idx].last, out_q[idx].data} !== exp_q[idx]) mism++;
            end
            check($sformatf("%s_blk%0d_mismatches", tag, b), 64'(mism), 64'd0);
        end
        out_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int vals[64];
        int row01[16] = '{0, 1, 5, 6, 14, 15, 27, 28, 2, 4, 7, 13, 16, 26, 29, 42};
        int base_in, base_err, base_stall, base_rdy, base_unst;
        bit fill_mode;
`ifdef INV_ZZ_EOB_FILL_EN
        fill_mode = 1'b1;
`else
        fill_mode = 1'b0;
`endif
        build_model();
        zz_if.tvalid = 1'b0; zz_if.tlast = 1'b0; zz_if.tdata = '0;
        zz_if.tkeep = '1; zz_if.tstrb = '1; zz_if.tid = '0; zz_if.tdest = '0; zz_if.tuser = '0;
        rs_if.tready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", 64'(rs_if.tvalid), 64'd0);
        check("rst_tlast",  64'(rs_if.tlast),  64'd0);
        check("rst_err",    64'(err),          64'd0);
        check("rst_full",   64'(dut.full_q),   64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("tready_after_rst", 64'(zz_if.tready), 64'd1);

        // Single block, tdata = zig-zag index
        base_err = n_err;
        for (int k = 0; k < 64; k++) vals[k] = k;
        push_block(vals, 63, fill_mode);
        drain("single", 100, 100, 400);
        for (int i = 0; i < 16; i++)
            check($sformatf("single_raster%0d", i), 64'(out_q[i].data), 64'(row01[i]));
        check("single_last_data", 64'(out_q[63].data), 64'd63);
        check("single_last_tlast", 64'(out_q[63].last), 64'd1);
        check("single_latency", 64'(vld_rise_cyc), 64'(t_last_in + 1));
        check("single_err", 64'(n_err - base_err), 64'd0);
        compare_out("single");

        // Four back-to-back blocks
        base_stall = n_src_stall;
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 64; k++) vals[k] = 64 * b + k;
            push_block(vals, 63, fill_mode);
        end
        drain("b2b", 100, 100, 800);
        check("b2b_no_gaps", 64'(out_q[255].cyc - out_q[0].cyc), 64'd255);
        check("b2b_tready_held", 64'(n_src_stall - base_stall), 64'd0);
        compare_out("b2b");

        // Sink stalled: two blocks fill both banks, then input stalls
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < 64; k++) vals[k] = $urandom_range(4095);
            push_block(vals, 63, fill_mode);
        end
        base_in = n_in;
        for (int c = 0; c < 200; c++) step(100, 0);
        check("stall_accepted", 64'(n_in - base_in), 64'd128);
        check("stall_tready", 64'(zz_if.tready), 64'd0);
        check("stall_no_out", 64'(out_q.size()), 64'd0);
        drain("stall", 100, 100, 800);
        compare_out("stall");

        // Random valid/ready over 20 blocks
        base_unst = n_unstable;
        base_err  = n_err;
        for (int b = 0; b < 20; b++) begin
            for (int k = 0; k < 64; k++) vals[k] = $urandom_range(4095);
            push_block(vals, 63, fill_mode);
        end
        drain("rand", 50, 50, 20000);
        check("rand_stable", 64'(n_unstable - base_unst), 64'd0);
        check("rand_err", 64'(n_err - base_err), 64'd0);
        compare_out("rand");

        // Early tlast at zig-zag index 5
        base_err = n_err;
        base_rdy = n_rdy_low;
        for (int k = 0; k < 64; k++) vals[k] = k + 1;
        push_block(vals, 5, fill_mode);
        drain("eob", 100, 100, 400);
        if (fill_mode) begin
            check("eob_fill_cycles", 64'(n_rdy_low - base_rdy), 64'd58);
            check("eob_err", 64'(n_err - base_err), 64'd0);
        end else begin
            check("eob_err", 64'(n_err - base_err), 64'd1);
        end
        compare_out("eob");

        // Reset in the middle of a block
        for (int k = 0; k < 64; k++) vals[k] = $urandom_range(4095);
        push_block(vals, 63, fill_mode);
        base_in = n_in;
        for (int c = 0; c < 200 && (n_in - base_in) < 30; c++) step(100, 100);
        check("midrst_reached30", 64'((n_in - base_in) >= 30), 64'd1);
        zz_if.tvalid = 1'b0;
        zz_if.tlast  = 1'b0;
        src_q.delete();
        exp_q.delete();
        rst = 1'b1;
        #1;
        check("midrst_tvalid", 64'(rs_if.tvalid), 64'd0);
        check("midrst_full", 64'(dut.full_q), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_tready", 64'(zz_if.tready), 64'd1);
        for (int c = 0; c < 80; c++) step(100, 100);
        check("midrst_no_out", 64'(out_q.size()), 64'd0);
        for (int k = 0; k < 64; k++) vals[k] = $urandom_range(4095);
        push_block(vals, 63, fill_mode);
        drain("postrst", 100, 100, 400);
        compare_out("postrst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
